fifo_rd_cntrl: RTL and testbench
================================

// Module: fifo_rd_cntrl
// PURPOSE
//  Read-side controller for the async FIFO, in the read clock domain.
//  - Owns the read pointer and drives raddr into the FIFO memory.
//  - Takes combinational rdata back from the memory.
//  - Generates the empty flag and a fill-level estimate.
//  - Drains the memory into a one-entry output register with a valid/ready handshake.
//  - Exports the Gray read pointer for synchronisation into the write domain.
// PARAMETERS
//  ADDR_WIDTH  4  pointer width incl. wrap bit; memory address = ADDR_WIDTH-1 bits, DEPTH = 2^(ADDR_WIDTH-1)
//  DATA_WIDTH  8  word width, matches the FIFO memory
// PORTS
//  rclk       in   1             read-domain clock, all state on posedge
//  rrst       in   1             asynchronous, active-high reset
//  rq2_wptr   in   ADDR_WIDTH    Gray write pointer, already 2-flop synchronised to rclk
//  rdata      in   DATA_WIDTH    memory read data at raddr (combinational from memory)
//  raddr      out  ADDR_WIDTH-1  memory read address = rbin[ADDR_WIDTH-2:0]
//  rptr       out  ADDR_WIDTH    registered Gray read pointer, to write-domain synchroniser
//  rempty     out  1             registered memory-empty flag
//  rlevel     out  ADDR_WIDTH    registered entries in memory, 0..DEPTH (output register excluded)
//  out_data   out  DATA_WIDTH    output word
//  out_valid  out  1             out_data holds a valid word
//  out_ready  in   1             consumer accepts; transfer = out_valid & out_ready at posedge
// BEHAVIOUR
//  - Reset (rrst=1, takes effect immediately, no clock required):
//      rbin=0, rptr=0, rempty=1, rlevel=0, out_valid=0, out_data=0.
//      Memory contents are not touched. System resets both FIFO domains together.
//  - Pop: pop = ~rempty & (~out_valid | out_ready).
//      On pop: out_data<=rdata, out_valid<=1, rbin<=rbin+1.
//  - Drain: transfer without pop -> out_valid<=0.
//      No transfer and no pop -> out_data and out_valid hold.
//  - Next-pointer arithmetic:
//      rbin_next = rbin + pop, modulo 2^ADDR_WIDTH (natural wrap; MSB is the lap bit).
//      rgray_next = (rbin_next>>1) ^ rbin_next.
//      rptr <= rgray_next.
//  - Empty: rempty <= (rgray_next == rq2_wptr).
//  - Level: rlevel <= gray2bin(rq2_wptr) - rbin_next, modulo 2^ADDR_WIDTH.
//      rlevel == DEPTH means the memory is full.
//  - Latency:
//      rq2_wptr changes before edge N -> rempty=0 after edge N -> out_valid=1 after edge N+1.
//  - Throughput: with out_ready held 1 and the memory non-empty, one word per clock, no bubbles.
//  - Order: words leave strictly in write order across pointer wrap. raddr wraps DEPTH-1 -> 0.
//  - Last word, simultaneous pop and transfer: out_valid stays 1, next word loaded, rempty rises.
//  - Never pops when rempty=1.
//      rempty is conservative: it may lag a write by the synchroniser delay, never leads it.
//  - out_valid may not drop without a transfer.
//      out_data is stable while out_valid & ~out_ready.
//  - Reset mid-transfer: the word in the output register is discarded. No partial state survives.
// TESTING
//  1. Reset: pulse rrst mid-stream, no clock edge
//     -> out_valid=0, out_data=0, rempty=1, rptr=0, raddr=0, rlevel=0 immediately.
//  2. Single word: rq2_wptr 0000->0001, rdata=8'hA5, out_ready=0
//     -> edge1: rempty=0, rlevel=1;
//     -> edge2: out_valid=1, out_data=A5, raddr=1, rptr=0001, rempty=1, rlevel=0.
//  3. Backpressure: 3 words, out_ready=0
//     -> one pop only, out_data=word0 held, raddr=1, rlevel=2;
//     -> out_ready=1: word0, word1, word2 on consecutive edges, then out_valid=0.
//  4. Wrap: stream 20 words, DEPTH 8, out_ready=1
//     -> raddr 7->0 twice, rptr passes 0100->1100, data order exact, no drops or duplicates.
//  5. Full: rbin=0, rq2_wptr=1100 (bin 8)
//     -> rlevel=8, rempty=0.
//  6. Random: random out_ready plus random write pattern vs scoreboard
//     -> no loss or reorder; out_data stable while stalled; no pop when rempty=1.

Source files
------------

// File: rtl/fifo_rd_cntrl_if.sv
// Read-side port bundle of the async FIFO: write-pointer sync input, memory
// read port, status outputs and the output-register valid/ready handshake.
interface fifo_rd_cntrl_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] rq2_wptr;
   logic [DATA_WIDTH-1:0] rdata;
   logic [ADDR_WIDTH-2:0] raddr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic                  rempty;
   logic [ADDR_WIDTH-1:0] rlevel;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   // master = the read controller, slave = memory/synchroniser/consumer side
   modport master (
      input  rq2_wptr, rdata, out_ready,
      output raddr, rptr, rempty, rlevel, out_data, out_valid
   );

   modport slave (
      output rq2_wptr, rdata, out_ready,
      input  raddr, rptr, rempty, rlevel, out_data, out_valid
   );
endinterface

// File: rtl/fifo_rd_cntrl.sv
// Async FIFO read-domain controller: owns the read pointer, computes empty and
// fill level, and drains the memory into a one-entry valid/ready output stage.
module fifo_rd_cntrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic              rclk,
   input  logic              rrst,
   fifo_rd_cntrl_if.master   bus
);

   logic [ADDR_WIDTH-1:0] rbin_q, rbin_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rgray_d;
   logic                  rempty_q, rempty_d;
   logic [ADDR_WIDTH-1:0] rlevel_q, rlevel_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic [ADDR_WIDTH-1:0] wbin;
   logic                  pop;

   function automatic logic [ADDR_WIDTH-1:0] gray2bin(input logic [ADDR_WIDTH-1:0] g);
      logic [ADDR_WIDTH-1:0] b;
      b[ADDR_WIDTH-1] = g[ADDR_WIDTH-1];
      for (int i = ADDR_WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_comb begin
      wbin     = gray2bin(bus.rq2_wptr);
      // Refill the output stage whenever it is empty or being emptied this edge
      pop      = ~rempty_q & (~out_valid_q | bus.out_ready);
      rbin_d   = rbin_q + {{(ADDR_WIDTH-1){1'b0}}, pop};
      rgray_d  = (rbin_d >> 1) ^ rbin_d;
      rempty_d = (rgray_d == bus.rq2_wptr);
      rlevel_d = wbin - rbin_d;

      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (pop) begin
         out_data_d  = bus.rdata;
         out_valid_d = 1'b1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin_q      <= '0;
         rptr_q      <= '0;
         rempty_q    <= 1'b1;
         rlevel_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         rbin_q      <= rbin_d;
         rptr_q      <= rgray_d;
         rempty_q    <= rempty_d;
         rlevel_q    <= rlevel_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.raddr     = rbin_q[ADDR_WIDTH-2:0];
   assign bus.rptr      = rptr_q;
   assign bus.rempty    = rempty_q;
   assign bus.rlevel    = rlevel_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_rd_cntrl.sv
// Bench for fifo_rd_cntrl: a behavioural FIFO memory/write side feeds the DUT,
// expected words go into a queue and an independent monitor checks every transfer.
module tb_fifo_rd_cntrl;
   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rrst;
   always #5 clk = ~clk;

   fifo_rd_cntrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   fifo_rd_cntrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .rclk (clk),
      .rrst (rrst),
      .bus  (bus)
   );

   logic [DW-1:0] mem [DEPTH];
   assign bus.rdata = mem[bus.raddr];

   int            vectors     = 0;
   int            miscompares = 0;
   logic [DW-1:0] exp_q [$];
   logic [AW-1:0] wbin;
   int            wr_count, xfer_count, wraps;
   bit            lap_seen;
   bit            mon_skip;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      wbin          = '0;
      bus.rq2_wptr  = '0;
      bus.out_ready = 1'b0;
      wr_count      = 0;
      xfer_count    = 0;
      wraps         = 0;
      lap_seen      = 1'b0;
      mon_skip      = 1'b1;
   endtask

   // Memory write plus pointer publish; the synchroniser delay is modelled as zero
   task automatic write_word(input logic [DW-1:0] d);
      mem[wbin[AW-2:0]] = d;
      wbin              = wbin + 4'd1;
      bus.rq2_wptr      = wbin ^ (wbin >> 1);
      exp_q.push_back(d);
      wr_count++;
      $display("write #%0d data=%02h wptr_gray=%04b", wr_count, d, bus.rq2_wptr);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #2;
      rrst = 1'b1;
      clear_model();
      #2;
      rrst = 1'b0;
   endtask

   task automatic drain(input string name);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 100 && (exp_q.size() != 0 || bus.out_valid); i++) tick();
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({name, "_valid_low"}, 32'(bus.out_valid), 32'd0);
   endtask

   // Monitor: scoreboard on transfers, stall stability, no pop while empty
   logic          prev_ok, prev_stall, prev_rempty;
   logic [DW-1:0] prev_data;
   logic [AW-2:0] prev_raddr;
   logic [AW-1:0] prev_rptr;
   logic [DW-1:0] exp_w;

   always @(negedge clk) begin
      if (rrst || mon_skip) begin
         mon_skip = 1'b0;
         prev_ok  = 1'b0;
      end else begin
         if (prev_ok) begin
            if (prev_stall) begin
               check("stall_valid", 32'(bus.out_valid), 32'd1);
               check("stall_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (prev_rempty) check("no_pop_when_empty", 32'(bus.raddr), 32'(prev_raddr));
            if (prev_raddr == 3'd7 && bus.raddr == 3'd0) wraps++;
            if (prev_rptr == 4'b0100 && bus.rptr == 4'b1100) lap_seen = 1'b1;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_word", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
               exp_w = exp_q.pop_front();
               xfer_count++;
               $display("xfer #%0d data=%02h expected=%02h", xfer_count, bus.out_data, exp_w);
               check("sb_data", 32'(bus.out_data), 32'(exp_w));
            end
         end
         prev_ok     = 1'b1;
         prev_stall  = bus.out_valid & ~bus.out_ready;
         prev_data   = bus.out_data;
         prev_rempty = bus.rempty;
         prev_raddr  = bus.raddr;
         prev_rptr   = bus.rptr;
      end
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      rrst = 1'b0;
      clear_model();

      // Power-up reset, asynchronous: no clock edge before the check
      #1 rrst = 1'b1;
      #1;
      check("por_valid", 32'(bus.out_valid), 32'd0);
      check("por_rempty", 32'(bus.rempty), 32'd1);
      check("por_rptr", 32'(bus.rptr), 32'd0);
      #2 rrst = 1'b0;

      // Test 1: reset mid-stream, between clock edges
      tick();
      write_word(8'h5A); write_word(8'h6B); write_word(8'h7C);
      tick(); tick(); tick();
      check("t1_pre_valid", 32'(bus.out_valid), 32'd1);
      #1 rrst = 1'b1;
      clear_model();
      #1;
      check("t1_valid", 32'(bus.out_valid), 32'd0);
      check("t1_data", 32'(bus.out_data), 32'd0);
      check("t1_rempty", 32'(bus.rempty), 32'd1);
      check("t1_rptr", 32'(bus.rptr), 32'd0);
      check("t1_raddr", 32'(bus.raddr), 32'd0);
      check("t1_rlevel", 32'(bus.rlevel), 32'd0);
      #1 rrst = 1'b0;

      // Test 2: single word, consumer stalled
      tick();
      write_word(8'hA5);
      tick();
      check("t2_e1_rempty", 32'(bus.rempty), 32'd0);
      check("t2_e1_rlevel", 32'(bus.rlevel), 32'd1);
      check("t2_e1_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("t2_e2_valid", 32'(bus.out_valid), 32'd1);
      check("t2_e2_data", 32'(bus.out_data), 32'hA5);
      check("t2_e2_raddr", 32'(bus.raddr), 32'd1);
      check("t2_e2_rptr", 32'(bus.rptr), 32'b0001);
      check("t2_e2_rempty", 32'(bus.rempty), 32'd1);
      check("t2_e2_rlevel", 32'(bus.rlevel), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      check("t2_drained_valid", 32'(bus.out_valid), 32'd0);

      // Test 3: backpressure with three words
      reset_dut();
      tick();
      write_word(8'h11); write_word(8'h22); write_word(8'h33);
      tick();
      check("t3_e1_rempty", 32'(bus.rempty), 32'd0);
      check("t3_e1_rlevel", 32'(bus.rlevel), 32'd3);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
         check("t3_hold_data", 32'(bus.out_data), 32'h11);
         check("t3_hold_raddr", 32'(bus.raddr), 32'd1);
         check("t3_hold_rlevel", 32'(bus.rlevel), 32'd2);
      end
      bus.out_ready = 1'b1;
      tick();
      check("t3_w1_data", 32'(bus.out_data), 32'h22);
      check("t3_w1_valid", 32'(bus.out_valid), 32'd1);
      check("t3_w1_raddr", 32'(bus.raddr), 32'd2);
      tick();
      check("t3_w2_data", 32'(bus.out_data), 32'h33);
      check("t3_w2_valid", 32'(bus.out_valid), 32'd1);
      check("t3_w2_rempty", 32'(bus.rempty), 32'd1);
      tick();
      check("t3_end_valid", 32'(bus.out_valid), 32'd0);

      // Test 4: 20-word stream across two pointer wraps
      reset_dut();
      bus.out_ready = 1'b1;
      for (int c = 0; c < 300 && wr_count < 20; c++) begin
         tick();
         if (wr_count - xfer_count < DEPTH) write_word(8'(8'h40 + wr_count));
      end
      drain("t4");
      check("t4_xfers", 32'(xfer_count), 32'd20);
      check("t4_raddr_wraps", 32'(wraps), 32'd2);
      check("t4_rptr_lap", 32'(lap_seen), 32'd1);

      // Test 5: memory full
      reset_dut();
      tick();
      for (int i = 0; i < DEPTH; i++) write_word(8'(8'hC0 + i));
      tick();
      check("t5_full_rlevel", 32'(bus.rlevel), 32'd8);
      check("t5_full_rempty", 32'(bus.rempty), 32'd0);
      check("t5_full_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("t5_pop_data", 32'(bus.out_data), 32'hC0);
      check("t5_pop_rlevel", 32'(bus.rlevel), 32'd7);
      drain("t5");

      // Test 6: random writes and random backpressure
      reset_dut();
      for (int c = 0; c < 300; c++) begin
         tick();
         bus.out_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0 && wr_count - xfer_count < DEPTH)
            write_word(8'($urandom_range(0, 255)));
      end
      drain("t6");
      check("t6_xfers", 32'(xfer_count), 32'(wr_count));
      check("t6_rempty", 32'(bus.rempty), 32'd1);
      check("t6_rlevel", 32'(bus.rlevel), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
